io_port_bridge: RTL and testbench



---
 rtl/io_port_bridge.sv | 118 +++++++++++
 tb/tb_io_port_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// io_port_bridge: write FIFO from the execute-stage OUT strobe to a peripheral
// valid/ready port, plus peripheral-written input registers read by the CPU.
// Optional interrupt/ack feature enabled by defining IO_BRIDGE_IRQ_EN.
module io_port_bridge #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IN_PORTS   = 4,
  parameter logic [7:0]  IRQ_ACK_ID = 8'hFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        io_strb,
  input  logic [7:0]                  port_id,
  input  logic [7:0]                  out_port,
  output logic [7:0]                  in_port,
  output logic                        fifo_full,
  output logic                        ovf,
  output logic                        per_valid,
  output logic [7:0]                  per_id,
  output logic [7:0]                  per_data,
  input  logic                        per_ready,
  input  logic                        per_in_we,
  input  logic [$clog2(IN_PORTS)-1:0] per_in_idx,
  input  logic [7:0]                  per_in_data,
  output logic                        irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(IN_PORTS);
  localparam int unsigned ENT_W = 16;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [7:0]       in_reg [IN_PORTS];
  logic             ack_c;
  logic             push_c;
  logic             pop_c;
  logic             drop_c;

`ifdef IO_BRIDGE_IRQ_EN
  // Ack write is consumed here and never reaches the FIFO
  assign ack_c = io_strb & (port_id == IRQ_ACK_ID);
`else
  logic unused_ack_id;
  assign ack_c         = 1'b0;
  assign unused_ack_id = ^IRQ_ACK_ID;
`endif

  assign pop_c  = per_valid & per_ready;
  assign push_c = io_strb & ~ack_c & (~fifo_full | pop_c);
  assign drop_c = io_strb & ~ack_c & fifo_full & ~pop_c;

  // Head entry falls through directly from storage
  assign {per_id, per_data} = mem[rd_ptr];

  // Next occupancy from push/pop
  always_comb begin
    count_nxt = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO storage, pointers, occupancy and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      per_valid <= 1'b0;
      fifo_full <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= {port_id, out_port};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      per_valid <= (count_nxt != '0);
      fifo_full <= (count_nxt == CNT_W'(DEPTH));
      if (drop_c) ovf <= 1'b1;
    end
  end

  // Peripheral-written input registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(IN_PORTS); i++) in_reg[i] <= 8'h00;
    end else if (per_in_we) begin
      in_reg[per_in_idx] <= per_in_data;
    end
  end

  // CPU read mux; out-of-range port IDs read as zero
  always_comb begin
    in_port = 8'h00;
    if (32'(port_id) < IN_PORTS) in_port = in_reg[port_id[IDX_W-1:0]];
  end

`ifdef IO_BRIDGE_IRQ_EN
  // Interrupt: set by any peripheral input write, cleared by ack; set wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           irq <= 1'b0;
    else if (per_in_we) irq <= 1'b1;
    else if (ack_c)     irq <= 1'b0;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed bench for io_port_bridge: queue-based reference model checked on
// every falling edge, plus literal expectations at key points.
module tb_io_port_bridge;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned IN_PORTS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       io_strb = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_port;
  logic       fifo_full;
  logic       ovf;
  logic       per_valid;
  logic [7:0] per_id;
  logic [7:0] per_data;
  logic       per_ready = 1'b0;
  logic       per_in_we = 1'b0;
  logic [1:0] per_in_idx = 2'd0;
  logic [7:0] per_in_data = 8'h00;
  logic       irq;

  int errors = 0;
  int checks = 0;

  io_port_bridge #(.DEPTH(DEPTH), .IN_PORTS(IN_PORTS), .IRQ_ACK_ID(8'hFF)) dut (
    .clk(clk), .rst(rst), .io_strb(io_strb), .port_id(port_id), .out_port(out_port),
    .in_port(in_port), .fifo_full(fifo_full), .ovf(ovf), .per_valid(per_valid),
    .per_id(per_id), .per_data(per_data), .per_ready(per_ready),
    .per_in_we(per_in_we), .per_in_idx(per_in_idx), .per_in_data(per_in_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {id,data}, a sticky overflow bit, input regs, irq
  logic [15:0] mq[$];
  logic        m_ovf;
  logic [7:0]  m_in [IN_PORTS];
  logic        m_irq;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_irq = 1'b0;
      for (int i = 0; i < IN_PORTS; i++) m_in[i] = 8'h00;
    end else begin
      bit pop, push, ack;
      ack = 1'b0;
`ifdef IO_BRIDGE_IRQ_EN
      ack = io_strb && (port_id == 8'hFF);
`endif
      pop  = per_ready && (mq.size() != 0);
      push = io_strb && !ack && ((mq.size() < DEPTH) || pop);
      if (io_strb && !ack && !push) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({port_id, out_port});
`ifdef IO_BRIDGE_IRQ_EN
      if (per_in_we) m_irq = 1'b1;
      else if (ack)  m_irq = 1'b0;
`endif
      if (per_in_we) m_in[per_in_idx] = per_in_data;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      check("per_valid", 32'(per_valid), 32'(mq.size() != 0));
      check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("irq", 32'(irq), 32'(m_irq));
      check("in_port", 32'(in_port), (port_id < IN_PORTS) ? 32'(m_in[port_id[1:0]]) : 32'h0);
      if (mq.size() != 0) begin
        check("per_id", 32'(per_id), 32'(mq[0][15:8]));
        check("per_data", 32'(per_data), 32'(mq[0][7:0]));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] id, input logic [7:0] d);
    io_strb  = 1'b1;
    port_id  = id;
    out_port = d;
    cyc();
    io_strb  = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_per_valid", 32'(per_valid), 32'h0);
    check("rst_per_id", 32'(per_id), 32'h00);
    check("rst_per_data", 32'(per_data), 32'h00);
    check("rst_fifo_full", 32'(fifo_full), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc();

    // 1: fall-through head, hold while not ready, drain in order
    per_ready = 1'b0;
    strobe(8'h10, 8'hA1);
    check("t1_valid", 32'(per_valid), 32'h1);
    check("t1_id", 32'(per_id), 32'h10);
    check("t1_data", 32'(per_data), 32'hA1);
    strobe(8'h11, 8'hA2);
    strobe(8'h12, 8'hA3);
    cyc(2);
    check("t1_hold_id", 32'(per_id), 32'h10);
    check("t1_hold_data", 32'(per_data), 32'hA1);
    per_ready = 1'b1;
    cyc();
    check("t1_pop1_id", 32'(per_id), 32'h11);
    cyc();
    check("t1_pop2_id", 32'(per_id), 32'h12);
    cyc();
    check("t1_empty", 32'(per_valid), 32'h0);
    per_ready = 1'b0;

    // 2: fill, overflow drop, then full write accepted alongside a pop
    for (int i = 0; i < 4; i++) strobe(8'(8'h01 + i), 8'(8'hB1 + i));
    check("t2_full", 32'(fifo_full), 32'h1);
    strobe(8'h20, 8'h55);
    check("t2_ovf", 32'(ovf), 32'h1);
    check("t2_full_after_drop", 32'(fifo_full), 32'h1);
    check("t2_head_after_drop", 32'(per_id), 32'h01);
    per_ready = 1'b1;
    strobe(8'h21, 8'h66);
    per_ready = 1'b0;
    check("t2_full_after_pushpop", 32'(fifo_full), 32'h1);
    check("t2_head_after_pushpop", 32'(per_id), 32'h02);
    per_ready = 1'b1;
    cyc(3);
    check("t2_tail_id", 32'(per_id), 32'h21);
    check("t2_tail_data", 32'(per_data), 32'h66);
    cyc();
    per_ready = 1'b0;
    check("t2_drained", 32'(per_valid), 32'h0);

    // 3: count=1 with simultaneous push and pop
    strobe(8'h30, 8'hC0);
    per_ready = 1'b1;
    strobe(8'h31, 8'hC1);
    check("t3_valid", 32'(per_valid), 32'h1);
    check("t3_head", 32'(per_id), 32'h31);
    cyc();
    per_ready = 1'b0;
    check("t3_empty", 32'(per_valid), 32'h0);

    // 4: input registers, out-of-range read, write/read same cycle
    per_in_we = 1'b1; per_in_idx = 2'd2; per_in_data = 8'h5C;
    cyc();
    per_in_we = 1'b0;
    port_id = 8'd2; #1;
    check("t4_read2", 32'(in_port), 32'h5C);
    port_id = 8'd9; #1;
    check("t4_read9", 32'(in_port), 32'h00);
    port_id = 8'd2;
    per_in_we = 1'b1; per_in_data = 8'h77; #1;
    check("t4_old_value", 32'(in_port), 32'h5C);
    cyc();
    per_in_we = 1'b0;
    check("t4_new_value", 32'(in_port), 32'h77);

    // 5: asynchronous reset mid-cycle with entries queued and ovf set
    strobe(8'h40, 8'hD0);
    strobe(8'h41, 8'hD1);
    strobe(8'h42, 8'hD2);
    check("t5_ovf_before", 32'(ovf), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("t5_valid_rst", 32'(per_valid), 32'h0);
    check("t5_ovf_rst", 32'(ovf), 32'h0);
    check("t5_full_rst", 32'(fifo_full), 32'h0);
    check("t5_inreg_rst", 32'(in_port), 32'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc();
    strobe(8'h50, 8'hC5);
    check("t5_first_id", 32'(per_id), 32'h50);
    check("t5_first_data", 32'(per_data), 32'hC5);
    per_ready = 1'b1;
    cyc();
    per_ready = 1'b0;

`ifdef IO_BRIDGE_IRQ_EN
    // 6: interrupt set, ack clears without queuing, set wins over ack
    per_in_we = 1'b1; per_in_idx = 2'd1; per_in_data = 8'h11;
    cyc();
    per_in_we = 1'b0;
    check("t6_irq_set", 32'(irq), 32'h1);
    strobe(8'hFF, 8'h00);
    check("t6_irq_ack", 32'(irq), 32'h0);
    check("t6_ack_not_queued", 32'(per_valid), 32'h0);
    per_in_we = 1'b1;
    strobe(8'hFF, 8'h00);
    per_in_we = 1'b0;
    check("t6_set_wins", 32'(irq), 32'h1);
    check("t6_ack2_not_queued", 32'(per_valid), 32'h0);
`else
    // 6: without the feature, port 0xFF is an ordinary write and irq stays 0
    per_in_we = 1'b1; per_in_idx = 2'd1; per_in_data = 8'h11;
    cyc();
    per_in_we = 1'b0;
    check("t6_irq_off", 32'(irq), 32'h0);
    strobe(8'hFF, 8'h99);
    check("t6_ff_queued", 32'(per_valid), 32'h1);
    check("t6_ff_id", 32'(per_id), 32'hFF);
    check("t6_ff_data", 32'(per_data), 32'h99);
    per_ready = 1'b1;
    cyc();
    per_ready = 1'b0;
`endif

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
